// File: rtl/alm_sweep_engine.sv
// Sweep engine for approximate-multiplier accuracy runs: issues every signed
// operand pair, tracks exact products in a FIFO and accumulates error stats.
module alm_sweep_engine #(
    parameter int DWIDTH     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_req_valid,
    input  logic                  i_req_ready,
    output logic [DWIDTH-1:0]     o_a,
    output logic [DWIDTH-1:0]     o_b,
    input  logic                  i_rsp_valid,
    input  logic [2*DWIDTH-1:0]   i_rsp_z,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DWIDTH:0]     o_sum_ed,
    output logic [2*DWIDTH:0]     o_max_ed,
    output logic [2*DWIDTH:0]     o_nz_cnt,
    output logic [2*DWIDTH:0]     o_err_cnt,
    output logic                  o_proto_err
);

    localparam int PW = 2 * DWIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [DWIDTH-1:0] OP_MIN = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic [DWIDTH-1:0] OP_MAX = {1'b0, {(DWIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DWIDTH-1:0] a;
    logic [DWIDTH-1:0] b;
    logic [PW-1:0]     mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       level;
    logic              full;
    logic              empty;
    logic              active;
    logic              start_ok;
    logic              push;
    logic              pop;
    logic              bad_rsp;
    logic              last;
    logic signed [PW-1:0] a_x;
    logic signed [PW-1:0] b_x;
    logic signed [PW-1:0] exact;
    logic [PW-1:0]     head;
    logic signed [PW:0] diff;
    logic [PW:0]       ed;

    assign level  = wr_ptr - rd_ptr;
    assign full   = level[AW];
    assign empty  = (level == '0);
    assign active = (state == RUN) || (state == DRAIN);

    assign start_ok    = i_start && ((state == IDLE) || (state == DONE));
    assign o_req_valid = (state == RUN) && !full;
    assign push        = o_req_valid && i_req_ready;
    assign last        = push && (a == OP_MAX) && (b == OP_MAX);

    assign a_x   = {{DWIDTH{a[DWIDTH-1]}}, a};
    assign b_x   = {{DWIDTH{b[DWIDTH-1]}}, b};
    assign exact = a_x * b_x;

    // An empty FIFO forwards the product being pushed, so zero-latency
    // responses pair with the request of the same cycle.
    assign head    = empty ? exact : mem[rd_ptr[AW-1:0]];
    assign pop     = i_rsp_valid && active && (!empty || push);
    assign bad_rsp = i_rsp_valid && !pop;

    assign diff = {head[PW-1], head} - {i_rsp_z[PW-1], i_rsp_z};
    assign ed   = diff[PW] ? (~diff + 1'b1) : diff;

    assign o_a    = a;
    assign o_b    = b;
    assign o_busy = active;
    assign o_done = (state == DONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN:     if (last) state_nxt = DRAIN;
            DRAIN:   if (empty) state_nxt = DONE;
            DONE:    if (start_ok) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= exact;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a           <= '0;
            b           <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_sum_ed    <= '0;
            o_max_ed    <= '0;
            o_nz_cnt    <= '0;
            o_err_cnt   <= '0;
            o_proto_err <= 1'b0;
        end else begin
            if (bad_rsp) begin
                o_proto_err <= 1'b1;
            end
            if (start_ok) begin
                a         <= OP_MIN;
                b         <= OP_MIN;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                o_sum_ed  <= '0;
                o_max_ed  <= '0;
                o_nz_cnt  <= '0;
                o_err_cnt <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (b == OP_MAX) begin
                        b <= OP_MIN;
                        a <= a + 1'b1;
                    end else begin
                        b <= b + 1'b1;
                    end
                end
                if (pop) begin
                    rd_ptr    <= rd_ptr + 1'b1;
                    o_sum_ed  <= o_sum_ed + {{PW{1'b0}}, ed};
                    o_nz_cnt  <= o_nz_cnt + {{PW{1'b0}}, (head != '0)};
                    o_err_cnt <= o_err_cnt + {{PW{1'b0}}, (ed != '0)};
                    if (ed > o_max_ed) begin
                        o_max_ed <= ed;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alm_sweep_engine.sv
// Bench for alm_sweep_engine at DWIDTH=4: a behavioural multiplier model
// answers requests, and a table-driven reference predicts the statistics.
module tb_alm_sweep_engine;

    localparam int DW = 4;
    localparam int FD = 8;
    localparam int PW = 2 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          rsp_valid;
    logic [PW-1:0] rsp_z;
    logic          busy;
    logic          done;
    logic [4*DW:0] sum_ed;
    logic [PW:0]   max_ed;
    logic [PW:0]   nz_cnt;
    logic [PW:0]   err_cnt;
    logic          proto;

    int n_cmp = 0;
    int n_bad = 0;

    logic [PW-1:0] zrec [256];
    int exp_sum;
    int exp_max;
    int exp_nz;
    int exp_err;

    always #5 clk = ~clk;

    alm_sweep_engine #(.DWIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .o_req_valid (req_valid),
        .i_req_ready (req_ready),
        .o_a         (a),
        .o_b         (b),
        .i_rsp_valid (rsp_valid),
        .i_rsp_z     (rsp_z),
        .o_busy      (busy),
        .o_done      (done),
        .o_sum_ed    (sum_ed),
        .o_max_ed    (max_ed),
        .o_nz_cnt    (nz_cnt),
        .o_err_cnt   (err_cnt),
        .o_proto_err (proto)
    );

    // mode 0: exact, 1: exact+1, 2: always zero, 3: random product
    task automatic build(input int mode);
        int e;
        int z;
        int ed;
        exp_sum = 0;
        exp_max = 0;
        exp_nz  = 0;
        exp_err = 0;
        for (int i = -8; i < 8; i++) begin
            for (int j = -8; j < 8; j++) begin
                e = i * j;
                case (mode)
                    0: z = e;
                    1: z = e + 1;
                    2: z = 0;
                    default: z = int'($urandom_range(0, 255)) - 128;
                endcase
                zrec[(i + 8) * 16 + (j + 8)] = z[PW-1:0];
                ed = (e > z) ? e - z : z - e;
                exp_sum += ed;
                if (ed > exp_max) exp_max = ed;
                if (e != 0) exp_nz++;
                if (ed != 0) exp_err++;
            end
        end
    endtask

    task automatic run_sweep(input int lat, input bit rnd_rdy,
                             input int poke, input int abort_at,
                             output int cycles, output int infl);
        int due_q[$];
        logic [PW-1:0] z_q[$];
        int k;
        int cyc;
        int outst;
        int ea;
        int eb;
        int idx;
        bit stalled;
        logic [DW-1:0] pa;
        logic [DW-1:0] pb;
        k = 0;
        cyc = 0;
        outst = 0;
        stalled = 0;
        pa = '0;
        pb = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && cyc < 3000) begin
            if (cyc == 0) begin
                n_cmp++;
                if ({busy, done} !== 2'b10) begin
                    n_bad++;
                    $display("FAIL sweep_begin busy/done=%b want 10", {busy, done});
                end
            end
            if (stalled) begin
                n_cmp++;
                if (a !== pa || b !== pb) begin
                    n_bad++;
                    $display("FAIL stall_hold a=%0d b=%0d want a=%0d b=%0d",
                             $signed(a), $signed(b), $signed(pa), $signed(pb));
                end
            end
            req_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (poke >= 0) && (k == poke);
            rsp_valid = 1'b0;
            rsp_z = '0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                rsp_valid = 1'b1;
                rsp_z = z_q.pop_front();
                outst--;
            end
            if (req_valid && req_ready) begin
                ea = k / 16 - 8;
                eb = k % 16 - 8;
                n_cmp++;
                if ($signed(a) != ea || $signed(b) != eb) begin
                    n_bad++;
                    $display("FAIL order k=%0d a=%0d b=%0d want a=%0d b=%0d",
                             k, $signed(a), $signed(b), ea, eb);
                end
                idx = (int'($signed(a)) + 8) * 16 + (int'($signed(b)) + 8);
                outst++;
                if (lat == 0) begin
                    rsp_valid = 1'b1;
                    rsp_z = zrec[idx];
                    outst--;
                end else begin
                    due_q.push_back(cyc + lat);
                    z_q.push_back(zrec[idx]);
                end
                k++;
                n_cmp++;
                if (outst > FD) begin
                    n_bad++;
                    $display("FAIL fifo_depth outstanding=%0d want <=%0d", outst, FD);
                end
            end
            stalled = req_valid && !req_ready;
            pa = a;
            pb = b;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (abort_at >= 0 && k >= abort_at) break;
        end
        rsp_valid = 1'b0;
        rsp_z = '0;
        start = 1'b0;
        req_ready = 1'b1;
        cycles = cyc;
        infl = due_q.size();
        if (abort_at < 0) begin
            n_cmp++;
            if (!done || k != 256) begin
                n_bad++;
                $display("FAIL sweep_end done=%b transfers=%0d want 1/256", done, k);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({req_valid, busy, done, proto, a, b} !== '0) begin
            n_bad++;
            $display("FAIL reset_ctrl v=%b busy=%b done=%b perr=%b a=%0d b=%0d want 0",
                     req_valid, busy, done, proto, a, b);
        end
        n_cmp++;
        if ({sum_ed, max_ed, nz_cnt, err_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_stats %0d %0d %0d %0d want 0",
                     sum_ed, max_ed, nz_cnt, err_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_sweep(input string name, input int mode,
                              input int lat, input bit rnd_rdy,
                              input int poke);
        int cyc;
        int infl;
        build(mode);
        run_sweep(lat, rnd_rdy, poke, -1, cyc, infl);
        n_cmp++;
        if (sum_ed !== 17'(exp_sum) || max_ed !== 9'(exp_max) ||
            nz_cnt !== 9'(exp_nz) || err_cnt !== 9'(exp_err)) begin
            n_bad++;
            $display("FAIL %s_stats sum=%0d max=%0d nz=%0d err=%0d want %0d %0d %0d %0d",
                     name, sum_ed, max_ed, nz_cnt, err_cnt,
                     exp_sum, exp_max, exp_nz, exp_err);
        end
        if (!rnd_rdy) begin
            n_cmp++;
            if (cyc != 257 + lat) begin
                n_bad++;
                $display("FAIL %s_latency cycles=%0d want %0d", name, cyc, 257 + lat);
            end
        end
    endtask

    task automatic test_proto_done;
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_z = 8'($urandom);
        @(negedge clk);
        rsp_valid = 1'b0;
        n_cmp++;
        if (proto !== 1'b1 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL proto_done perr=%b done=%b want 1 1", proto, done);
        end
        n_cmp++;
        if (sum_ed !== 17'(exp_sum) || max_ed !== 9'(exp_max) ||
            nz_cnt !== 9'(exp_nz) || err_cnt !== 9'(exp_err)) begin
            n_bad++;
            $display("FAIL proto_done_stats sum=%0d max=%0d nz=%0d err=%0d want %0d %0d %0d %0d",
                     sum_ed, max_ed, nz_cnt, err_cnt,
                     exp_sum, exp_max, exp_nz, exp_err);
        end
    endtask

    task automatic test_mid_reset;
        int cyc;
        int infl;
        build(0);
        run_sweep(3, 1'b0, -1, 100, cyc, infl);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({req_valid, busy, done, proto, a, b, sum_ed, max_ed, nz_cnt, err_cnt} !== '0) begin
            n_bad++;
            $display("FAIL abort_reset v=%b busy=%b done=%b perr=%b sum=%0d nz=%0d want 0",
                     req_valid, busy, done, proto, sum_ed, nz_cnt);
        end
        rst = 1'b0;
        n_cmp++;
        if (infl < 1) begin
            n_bad++;
            $display("FAIL abort_inflight count=%0d want >=1", infl);
        end
        for (int i = 0; i < infl; i++) begin
            rsp_valid = 1'b1;
            rsp_z = 8'($urandom);
            @(negedge clk);
        end
        rsp_valid = 1'b0;
        n_cmp++;
        if (proto !== 1'b1 || busy !== 1'b0 ||
            {sum_ed, max_ed, nz_cnt, err_cnt} !== '0) begin
            n_bad++;
            $display("FAIL proto_idle perr=%b busy=%b sum=%0d nz=%0d want 1 0 0 0",
                     proto, busy, sum_ed, nz_cnt);
        end
        test_sweep("restart", 0, 0, 1'b0, -1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        rsp_z = '0;
        test_reset();
        test_sweep("exact", 0, 0, 1'b0, -1);
        n_cmp++;
        if (proto !== 1'b0 || nz_cnt !== 9'd225) begin
            n_bad++;
            $display("FAIL exact_clean perr=%b nz=%0d want 0 225", proto, nz_cnt);
        end
        test_sweep("plus_one", 1, 3, 1'b0, -1);
        test_sweep("stall", 0, 5, 1'b1, -1);
        test_sweep("zero", 2, 2, 1'b0, -1);
        n_cmp++;
        if (max_ed !== 9'd64 || err_cnt !== 9'd225) begin
            n_bad++;
            $display("FAIL zero_bound max=%0d err=%0d want 64 225", max_ed, err_cnt);
        end
        test_sweep("random", 3, int'($urandom_range(1, 4)), 1'b1, -1);
        test_sweep("start_ignored", 1, 1, 1'b0, 50);
        test_proto_done();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
